// File: rtl/fp_addsub.sv
// rtl/fp_addsub.sv - Parametrised IEEE-754 add/subtract, round-to-nearest-even, stb/ack handshake
module fp_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter bit FTZ   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXP_W+MAN_W:0] input_a,
    input  logic                 input_a_stb,
    output logic                 input_a_ack,
    input  logic [EXP_W+MAN_W:0] input_b,
    input  logic                 input_op,
    input  logic                 input_b_stb,
    output logic                 input_b_ack,
    output logic [EXP_W+MAN_W:0] output_z,
    output logic [3:0]           output_flags,
    output logic                 output_z_stb,
    input  logic                 output_z_ack
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 1;
    localparam int F  = MAN_W + 3;
    localparam int M  = MAN_W + 4;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {GET_A, GET_B, UNPACK, ALIGN, ADD, NORM, ROUND, PUT_Z} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, z_q, z_d;
    logic           op_q, op_d;
    logic           a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
    logic [3:0]     flags_q, flags_d;
    logic           sa_q, sa_d, sb_q, sb_d, sign_q, sign_d, sub_q, sub_d;
    logic [EW-1:0]  ea_q, ea_d, eb_q, eb_d, e_q, e_d;
    logic [MAN_W:0] ma_q, ma_d, mb_q, mb_d;
    logic [M-1:0]   xa_q, xa_d, xb_q, xb_d, x_q, x_d;
    logic [M:0]     sum_q, sum_d;

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_q;
    assign output_flags = flags_q;
    assign output_z_stb = z_stb_q;

    // Field extraction and special-operand resolution
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_sgn, b_sgn, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, sp;
    logic [EW-1:0]    a_e_u, b_e_u;
    logic [MAN_W:0]   a_m_u, b_m_u;
    logic [W-1:0]     sp_z;
    logic [3:0]       sp_flags;

    always_comb begin
        a_sgn  = a_q[W-1];
        b_sgn  = b_q[W-1] ^ op_q;
        a_exp  = a_q[W-2:MAN_W];
        b_exp  = b_q[W-2:MAN_W];
        a_frac = a_q[MAN_W-1:0];
        b_frac = b_q[MAN_W-1:0];
        a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
        b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
        a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
        b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
        a_snan = a_nan && !a_frac[MAN_W-1];
        b_snan = b_nan && !b_frac[MAN_W-1];
        a_e_u  = (a_exp == '0) ? EW'(1) : {1'b0, a_exp};
        b_e_u  = (b_exp == '0) ? EW'(1) : {1'b0, b_exp};
        a_m_u  = (FTZ && a_exp == '0) ? '0 : {a_exp != '0, a_frac};
        b_m_u  = (FTZ && b_exp == '0) ? '0 : {b_exp != '0, b_frac};
        sp       = 1'b1;
        sp_z     = QNAN;
        sp_flags = 4'b0000;
        if (a_nan || b_nan)                        sp_flags = {a_snan || b_snan, 3'b000};
        else if (a_inf && b_inf && (a_sgn != b_sgn)) sp_flags = 4'b1000;
        else if (a_inf)                            sp_z = {a_sgn, EXP_ONES, {MAN_W{1'b0}}};
        else if (b_inf)                            sp_z = {b_sgn, EXP_ONES, {MAN_W{1'b0}}};
        else if (a_m_u == '0 && b_m_u == '0)       sp_z = {a_sgn & b_sgn, {(W-1){1'b0}}};
        else                                       sp = 1'b0;
    end

    // Alignment: smaller magnitude shifted right, shifted-out bits collapse into sticky
    logic          a_big, sm_st;
    logic [EW-1:0] diff;
    logic [F-1:0]  sm_full, sm_sh;

    always_comb begin
        a_big   = {ea_q, ma_q} >= {eb_q, mb_q};
        diff    = a_big ? (ea_q - eb_q) : (eb_q - ea_q);
        sm_full = {(a_big ? mb_q : ma_q), 2'b00};
        if (diff >= EW'(F)) begin
            sm_sh = '0;
            sm_st = |sm_full;
        end else begin
            sm_sh = sm_full >> diff;
            sm_st = |(sm_full & ~({F{1'b1}} << diff));
        end
    end

    // Normalisation: left shift is capped so the exponent never goes below 1
    logic [EW-1:0] lz, sh, ne;
    logic [M-1:0]  nx;

    always_comb begin
        lz = EW'(M);
        for (int i = 0; i < M; i++) begin
            if (sum_q[i]) lz = EW'(M - 1 - i);
        end
        sh = (lz > (e_q - EW'(1))) ? (e_q - EW'(1)) : lz;
        if (sum_q[M]) begin
            nx = {sum_q[M:2], sum_q[1] | sum_q[0]};
            ne = e_q + EW'(1);
        end else begin
            nx = sum_q[M-1:0] << sh;
            ne = e_q - sh;
        end
    end

    // Rounding and packing
    logic             rnd, inexact, tiny;
    logic [MAN_W+1:0] man_r;
    logic [MAN_W:0]   man_f;
    logic [EW-1:0]    e_f;
    logic [W-1:0]     r_z;
    logic [3:0]       r_flags;

    always_comb begin
        inexact = |x_q[2:0];
        rnd     = x_q[2] & (x_q[1] | x_q[0] | x_q[3]);
        man_r   = {1'b0, x_q[M-1:3]} + (MAN_W+2)'(rnd);
        if (man_r[MAN_W+1]) begin
            man_f = man_r[MAN_W+1:1];
            e_f   = e_q + EW'(1);
        end else begin
            man_f = man_r[MAN_W:0];
            e_f   = e_q;
        end
        tiny = !man_f[MAN_W];
        if (!tiny && e_f >= {1'b0, EXP_ONES}) begin
            r_z     = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
            r_flags = 4'b0101;
        end else if (FTZ && tiny && man_f != '0) begin
            r_z     = {sign_q, {(W-1){1'b0}}};
            r_flags = 4'b0011;
        end else begin
            r_z     = {sign_q, (tiny ? {EXP_W{1'b0}} : e_f[EXP_W-1:0]), man_f[MAN_W-1:0]};
            r_flags = {2'b00, tiny & inexact, inexact};
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        z_d     = z_q;
        flags_d = flags_q;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        z_stb_d = z_stb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        e_d     = e_q;
        xa_d    = xa_q;
        xb_d    = xb_q;
        sum_d   = sum_q;
        x_d     = x_q;
        case (state_q)
            GET_A: begin
                a_ack_d = 1'b1;
                if (input_a_stb && a_ack_q) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                b_ack_d = 1'b1;
                if (input_b_stb && b_ack_q) begin
                    b_d     = input_b;
                    op_d    = input_op;
                    b_ack_d = 1'b0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sa_d = a_sgn;
                sb_d = b_sgn;
                ea_d = a_e_u;
                eb_d = b_e_u;
                ma_d = a_m_u;
                mb_d = b_m_u;
                if (sp) begin
                    z_d     = sp_z;
                    flags_d = sp_flags;
                    z_stb_d = 1'b1;
                    state_d = PUT_Z;
                end else begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                sign_d  = a_big ? sa_q : sb_q;
                sub_d   = sa_q ^ sb_q;
                e_d     = a_big ? ea_q : eb_q;
                xa_d    = {(a_big ? ma_q : mb_q), 3'b000};
                xb_d    = {sm_sh, sm_st};
                state_d = ADD;
            end
            ADD: begin
                sum_d = sub_q ? ({1'b0, xa_q} - {1'b0, xb_q}) : ({1'b0, xa_q} + {1'b0, xb_q});
                if (sum_d == '0) sign_d = 1'b0;
                state_d = NORM;
            end
            NORM: begin
                x_d     = nx;
                e_d     = ne;
                state_d = ROUND;
            end
            ROUND: begin
                z_d     = r_z;
                flags_d = r_flags;
                z_stb_d = 1'b1;
                state_d = PUT_Z;
            end
            PUT_Z: begin
                if (z_stb_q && output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            z_q     <= '0;
            flags_q <= '0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            z_stb_q <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            e_q     <= '0;
            xa_q    <= '0;
            xb_q    <= '0;
            sum_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            z_q     <= z_d;
            flags_q <= flags_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            z_stb_q <= z_stb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            e_q     <= e_d;
            xa_q    <= xa_d;
            xb_q    <= xb_d;
            sum_q   <= sum_d;
            x_q     <= x_d;
        end
    end
endmodule
